// File: rtl/strength_if.sv
// Pixel-stream, accumulator-control and result signals of the strength sequencer.
// The master modport is the sequencer side; slave is the pixel source / accumulator side.
interface strength_if #(
    parameter int SW = 22
);
    logic          start;
    logic          pixel_valid;
    logic [7:0]    pixel_data;
    logic          pixel_ready;
    logic [7:0]    strength_input;
    logic          Radd_en;
    logic          Gadd_en;
    logic          Badd_en;
    logic          acc_clr;
    logic [SW-1:0] Rstrength;
    logic [SW-1:0] Gstrength;
    logic [SW-1:0] Bstrength;
    logic          busy;
    logic          done;
    logic [1:0]    color_class;
    logic [14:0]   pixel_count;

    modport master (
        input  start, pixel_valid, pixel_data,
        input  Rstrength, Gstrength, Bstrength,
        output pixel_ready, strength_input,
        output Radd_en, Gadd_en, Badd_en, acc_clr,
        output busy, done, color_class, pixel_count
    );

    modport slave (
        output start, pixel_valid, pixel_data,
        output Rstrength, Gstrength, Bstrength,
        input  pixel_ready, strength_input,
        input  Radd_en, Gadd_en, Badd_en, acc_clr,
        input  busy, done, color_class, pixel_count
    );
endinterface

// File: rtl/strength_sequencer.sv
// Frame controller: routes interleaved R,G,B bytes to the channel accumulator,
// counts pixels to the frame boundary, then classifies the dominant colour.
module strength_sequencer #(
    parameter int PIXELS = 16384,
    parameter int SW     = 22
) (
    input  logic      clk,
    input  logic      reset,
    strength_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [14:0] LAST_PIX = 15'(PIXELS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_phase;
    logic [14:0]   r_pixel_count;
    logic [7:0]    r_strength_input;
    logic [2:0]    r_add_en;
    logic [1:0]    r_color_class;

    logic          w_ready;
    logic          w_accept;
    logic          w_last_byte;
    logic          w_acc_clr;
    logic          w_busy;
    logic          w_done;
    logic [1:0]    w_class;
    logic [SW-1:0] w_r;
    logic [SW-1:0] w_g;
    logic [SW-1:0] w_b;

    assign w_ready     = (r_state == S_ACCUM);
    assign w_accept    = bus.pixel_valid && w_ready;
    assign w_last_byte = (r_phase == 2'd2) && (r_pixel_count == LAST_PIX);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next    = r_state;
        w_acc_clr = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_acc_clr = 1'b1;
                w_next    = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_accept && w_last_byte) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN:   w_next = S_COMPARE;
            S_COMPARE: w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Ties resolve toward the earlier channel: R over G over B.
    assign w_r = bus.Rstrength;
    assign w_g = bus.Gstrength;
    assign w_b = bus.Bstrength;

    always_comb begin
        w_class = 2'b00;
        if ((w_r == '0) && (w_g == '0) && (w_b == '0)) begin
            w_class = 2'b00;
        end else if ((w_r >= w_g) && (w_r >= w_b)) begin
            w_class = 2'b01;
        end else if (w_g >= w_b) begin
            w_class = 2'b10;
        end else begin
            w_class = 2'b11;
        end
    end

    // Enables are single-cycle: cleared every edge unless a byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase          <= 2'd0;
            r_pixel_count    <= 15'd0;
            r_strength_input <= 8'd0;
            r_add_en         <= 3'b000;
            r_color_class    <= 2'b00;
        end else begin
            r_add_en <= 3'b000;
            if (r_state == S_CLEAR) begin
                r_phase       <= 2'd0;
                r_pixel_count <= 15'd0;
            end
            if (w_accept) begin
                r_strength_input <= bus.pixel_data;
                case (r_phase)
                    2'd0:    r_add_en <= 3'b100;
                    2'd1:    r_add_en <= 3'b010;
                    default: r_add_en <= 3'b001;
                endcase
                if (r_phase == 2'd2) begin
                    r_phase       <= 2'd0;
                    r_pixel_count <= r_pixel_count + 15'd1;
                end else begin
                    r_phase <= r_phase + 2'd1;
                end
            end
            if (r_state == S_COMPARE) begin
                r_color_class <= w_class;
            end
        end
    end

    assign bus.pixel_ready    = w_ready;
    assign bus.strength_input = r_strength_input;
    assign bus.Radd_en        = r_add_en[2];
    assign bus.Gadd_en        = r_add_en[1];
    assign bus.Badd_en        = r_add_en[0];
    assign bus.acc_clr        = w_acc_clr;
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.color_class    = r_color_class;
    assign bus.pixel_count    = r_pixel_count;

endmodule

// File: tb/tb_strength_sequencer.sv
// Directed bench for strength_sequencer: a 4-pixel and a 2-pixel instance share
// stimulus; each feeds a behavioural channel accumulator.
module tb_strength_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic [7:0] pixel_data = 8'd0;
    logic       sel2 = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    strength_if #(.SW(22)) if4 ();
    strength_if #(.SW(22)) if2 ();

    assign if4.start       = start;
    assign if4.pixel_valid = pixel_valid;
    assign if4.pixel_data  = pixel_data;
    assign if2.start       = start;
    assign if2.pixel_valid = pixel_valid;
    assign if2.pixel_data  = pixel_data;

    strength_sequencer #(.PIXELS(4), .SW(22)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    strength_sequencer #(.PIXELS(2), .SW(22)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    // Channel accumulators: cleared only by acc_clr, never by reset.
    logic [21:0] r4 = '0, g4 = '0, b4 = '0;
    logic [21:0] r2 = '0, g2 = '0, b2 = '0;

    always @(posedge clk) begin
        if (if4.acc_clr) begin
            r4 <= '0; g4 <= '0; b4 <= '0;
        end else begin
            if (if4.Radd_en) r4 <= r4 + 22'(if4.strength_input);
            if (if4.Gadd_en) g4 <= g4 + 22'(if4.strength_input);
            if (if4.Badd_en) b4 <= b4 + 22'(if4.strength_input);
        end
        if (if2.acc_clr) begin
            r2 <= '0; g2 <= '0; b2 <= '0;
        end else begin
            if (if2.Radd_en) r2 <= r2 + 22'(if2.strength_input);
            if (if2.Gadd_en) g2 <= g2 + 22'(if2.strength_input);
            if (if2.Badd_en) b2 <= b2 + 22'(if2.strength_input);
        end
    end

    assign if4.Rstrength = r4;
    assign if4.Gstrength = g4;
    assign if4.Bstrength = b4;
    assign if2.Rstrength = r2;
    assign if2.Gstrength = g2;
    assign if2.Bstrength = b2;

    // Observation mux: sel2 picks which instance the current test watches.
    logic        ready, clr, busy, done;
    logic [2:0]  en;
    logic [7:0]  sin;
    logic [1:0]  cls;
    logic [14:0] cnt;
    logic [21:0] tr, tg, tb_t;

    assign ready = sel2 ? if2.pixel_ready : if4.pixel_ready;
    assign clr   = sel2 ? if2.acc_clr : if4.acc_clr;
    assign busy  = sel2 ? if2.busy : if4.busy;
    assign done  = sel2 ? if2.done : if4.done;
    assign en    = sel2 ? {if2.Radd_en, if2.Gadd_en, if2.Badd_en}
                        : {if4.Radd_en, if4.Gadd_en, if4.Badd_en};
    assign sin   = sel2 ? if2.strength_input : if4.strength_input;
    assign cls   = sel2 ? if2.color_class : if4.color_class;
    assign cnt   = sel2 ? if2.pixel_count : if4.pixel_count;
    assign tr    = sel2 ? r2 : r4;
    assign tg    = sel2 ? g2 : g4;
    assign tb_t  = sel2 ? b2 : b4;

    task automatic apply_reset();
        reset = 1'b0;
        start = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Drives one frame of identical pixels (pr,pg,pb) and checks every cycle
    // from CLEAR through the return to IDLE.
    task automatic run_frame(input string name, input logic [7:0] pr, input logic [7:0] pg,
                             input logic [7:0] pb, input int npix, input bit gaps,
                             input int start_at, input logic [1:0] exp_class,
                             input logic [21:0] er, input logic [21:0] eg, input logic [21:0] eb);
        logic [7:0] px [3];
        logic [7:0] b;
        logic [2:0] exp_en;
        px[0] = pr; px[1] = pg; px[2] = pb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (clr !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: acc_clr=%b busy=%b ready=%b, expected 1 1 0", name, clr, busy, ready);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || clr !== 1'b0 || cnt !== 15'd0 || en !== 3'b000) begin
            errors++;
            $display("FAIL %s accum_entry: ready=%b acc_clr=%b count=%0d en=%b, expected 1 0 0 000",
                     name, ready, clr, cnt, en);
        end
        for (int k = 0; k < 3 * npix; k++) begin
            b = px[k % 3];
            if (gaps) begin
                pixel_valid = 1'b0;
                @(negedge clk);
                checks++;
                if (en !== 3'b000) begin
                    errors++;
                    $display("FAIL %s gap%0d: en=%b, expected 000", name, k, en);
                end
            end
            start = (k == start_at);
            pixel_valid = 1'b1;
            pixel_data = b;
            @(negedge clk);
            start = 1'b0;
            exp_en = 3'b100 >> (k % 3);
            checks++;
            if (en !== exp_en || sin !== b || cnt !== 15'((k + 1) / 3)) begin
                errors++;
                $display("FAIL %s byte%0d: en=%b data=%0d count=%0d, expected %b %0d %0d",
                         name, k, en, sin, cnt, exp_en, b, (k + 1) / 3);
            end
        end
        pixel_valid = 1'b0;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: ready=%b done=%b busy=%b, expected 0 0 1", name, ready, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || en !== 3'b000 || tr !== er || tg !== eg || tb_t !== eb) begin
            errors++;
            $display("FAIL %s compare: done=%b en=%b totals=%0d/%0d/%0d, expected 0 000 %0d/%0d/%0d",
                     name, done, en, tr, tg, tb_t, er, eg, eb);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cls !== exp_class || cnt !== 15'(npix)) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b class=%b count=%0d, expected 1 1 %b %0d",
                     name, done, busy, cls, cnt, exp_class, npix);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cls !== exp_class || cnt !== 15'(npix)) begin
            errors++;
            $display("FAIL %s idle: done=%b busy=%b class=%b count=%0d, expected 0 0 %b %0d",
                     name, done, busy, cls, cnt, exp_class, npix);
        end
    endtask

    task automatic test_reset();
        sel2 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (en !== 3'b000 || sin !== 8'd0 || clr !== 1'b0 || ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || cls !== 2'b00 || cnt !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: en=%b data=%0d clr=%b ready=%b busy=%b done=%b class=%b count=%0d, expected all 0",
                     en, sin, clr, ready, busy, done, cls, cnt);
        end
        reset = 1'b1;
        pixel_valid = 1'b1;
        pixel_data = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || en !== 3'b000 || busy !== 1'b0 || sin !== 8'd0) begin
            errors++;
            $display("FAIL idle_valid_ignored: ready=%b en=%b busy=%b data=%0d, expected 0 000 0 0",
                     ready, en, busy, sin);
        end
        pixel_valid = 1'b0;
    endtask

    task automatic test_frame_r();
        sel2 = 1'b0;
        run_frame("frame_r", 8'd100, 8'd50, 8'd20, 4, 1'b0, -1, 2'b01, 22'd400, 22'd200, 22'd80);
    endtask

    task automatic test_gaps();
        sel2 = 1'b0;
        run_frame("gaps", 8'd100, 8'd50, 8'd20, 4, 1'b1, -1, 2'b01, 22'd400, 22'd200, 22'd80);
    endtask

    task automatic test_tie_and_zero();
        sel2 = 1'b1;
        apply_reset();
        run_frame("tie", 8'd10, 8'd10, 8'd5, 2, 1'b0, -1, 2'b01, 22'd20, 22'd20, 22'd10);
        run_frame("zero", 8'd0, 8'd0, 8'd0, 2, 1'b0, -1, 2'b00, 22'd0, 22'd0, 22'd0);
    endtask

    task automatic test_blue_start_ignored();
        sel2 = 1'b1;
        run_frame("blue", 8'd0, 8'd0, 8'd255, 2, 1'b0, 4, 2'b11, 22'd0, 22'd0, 22'd510);
    endtask

    task automatic test_reset_midframe();
        sel2 = 1'b0;
        apply_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            pixel_valid = 1'b1;
            pixel_data = (k % 3 == 0) ? 8'd100 : ((k % 3 == 1) ? 8'd50 : 8'd20);
            @(negedge clk);
        end
        checks++;
        if (cnt !== 15'd1 || en !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre: count=%0d en=%b busy=%b, expected 1 010 1", cnt, en, busy);
        end
        pixel_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (en !== 3'b000 || busy !== 1'b0 || ready !== 1'b0 || cnt !== 15'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: en=%b busy=%b ready=%b count=%0d done=%b, expected 000 0 0 0 0",
                     en, busy, ready, cnt, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_idle: busy=%b ready=%b, expected 0 0", busy, ready);
        end
        run_frame("fresh", 8'd100, 8'd50, 8'd20, 4, 1'b0, -1, 2'b01, 22'd400, 22'd200, 22'd80);
    endtask

    initial begin
        test_reset();
        test_frame_r();
        test_gaps();
        test_tie_and_zero();
        test_blue_start_ignored();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/strength_sequencer.md
Name: strength_sequencer

Overview:
Frame-level controller for the per-channel strength accumulator. Accepts an interleaved R,G,B pixel byte stream over a valid/ready handshake, routes each byte to the accumulator with the matching channel enable, and counts pixels to the frame boundary. At frame end it compares the three 22-bit channel totals, latches the dominant-colour class and pulses done. The sorting logic downstream bins the image from that class.

Parameters:
PIXELS, 16384, pixels per frame. 255*16384 fits in 22 bits; legal range 1..16384.
SW, 22, width of the channel strength totals read back from the accumulator.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin a frame; sampled only in IDLE.
pixel_valid  in  1  pixel_data holds a valid byte.
pixel_data  in  8  channel byte; per pixel the order is R, G, B.
pixel_ready  out  1  sequencer accepts a byte this cycle.
strength_input  out  8  registered byte to the accumulator.
Radd_en  out  1  accumulate strength_input into the R total.
Gadd_en  out  1  accumulate strength_input into the G total.
Badd_en  out  1  accumulate strength_input into the B total.
acc_clr  out  1  one-cycle clear pulse to the accumulator.
Rstrength  in  SW  R total from the accumulator.
Gstrength  in  SW  G total from the accumulator.
Bstrength  in  SW  B total from the accumulator.
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle pulse when color_class is valid.
color_class  out  2  00 all zero, 01 R dominant, 10 G dominant, 11 B dominant.
pixel_count  out  15  pixels fully accepted in the current frame.

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0: strength_input, enables, acc_clr, pixel_ready, busy, done, color_class, pixel_count. Phase counter 0.
- States: IDLE, CLEAR, ACCUM, DRAIN, COMPARE, DONE.
- IDLE:
  - start=1 moves to CLEAR and sets busy=1.
  - start=0 stays in IDLE.
  - color_class holds its last value.
- CLEAR (1 cycle):
  - acc_clr=1.
  - pixel_count and phase reset to 0.
  - Next state ACCUM.
- ACCUM:
  - pixel_ready=1.
  - A byte is accepted on the edge where pixel_valid && pixel_ready.
  - On acceptance: strength_input <= pixel_data, and exactly one enable is registered high by phase (0 R, 1 G, 2 B).
  - On a cycle with no acceptance, all enables are 0 in the following cycle.
  - Phase wraps 2 to 0, and pixel_count increments when a B byte is accepted.
  - Enables are never high for more than one cycle per accepted byte. At most one enable is high in any cycle.
- End of frame: on acceptance of the B byte with pixel_count==PIXELS-1:
  - pixel_ready drops the next cycle.
  - Next state DRAIN; Badd_en is high during DRAIN.
- DRAIN (1 cycle): accumulator absorbs the last byte. Next state COMPARE.
- COMPARE (1 cycle):
  - Totals are valid during this state.
  - color_class is registered at the end of COMPARE: 00 if all three totals are 0, otherwise the largest channel.
  - Ties resolve R > G > B.
- DONE (1 cycle):
  - done=1, busy=0 on exit.
  - Next state IDLE.
  - pixel_count holds PIXELS until the next CLEAR.
- Latency: done is asserted 3 cycles after the edge that accepted the last byte.
- start while busy is ignored.
- pixel_valid outside ACCUM is ignored (pixel_ready=0).
- Reset mid-frame: immediate return to IDLE with all enables low. The partial totals in the accumulator are cleared by the next frame's CLEAR.
- Compare uses unsigned SW-bit magnitudes; no saturation needed within the PIXELS range.

Test Plan:
- PIXELS=4; reset low then high; start; 4 pixels (100,50,20), pixel_valid held high -> 12 enable pulses in order R,G,B,R,…; Rstrength=400, Gstrength=200, Bstrength=80; color_class=01; done 3 cycles after the 12th acceptance; pixel_count=4.
- Same frame with pixel_valid low every other cycle -> no enable during gap cycles; identical totals and color_class=01; done 3 cycles after the last acceptance.
- PIXELS=2; pixels (10,10,5) and (10,10,5) -> R=G=20 tie; color_class=01. Second frame (0,0,0)x2 -> acc_clr pulse at its start; color_class=00.
- PIXELS=2; pixels (0,0,255)x2 -> B=510; color_class=11. start pulsed during ACCUM -> ignored; pixel_count sequence 0,1,2.
- reset=0 after 5 accepted bytes -> next cycle state IDLE, all enables 0, busy=0. A fresh frame then produces correct totals after acc_clr.
